// File: rtl/fifo2axi_arb.sv
// fifo2axi_arb: two-channel burst-locked arbiter merging the RDMAP-IQ cache
// writer (ch0) and the detection/log writer (ch1) onto one shared
// command-FIFO / write-data-FIFO pair that feeds the AXI DataMover.
// A grant is held until the owner drops its request and every beat
// announced by its commands has been written.
module fifo2axi_arb #(
    parameter int CMD_W = 64,
    parameter int DAT_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_ch0,
    input  logic             req_ch1,
    input  logic [CMD_W-1:0] fifo_din_cmd_ch0,
    input  logic             fifo_wr_en_cmd_ch0,
    output logic             fifo_full_cmd_ch0,
    input  logic [DAT_W-1:0] fifo_din_wr_ch0,
    input  logic             fifo_wr_en_wr_ch0,
    output logic             fifo_full_wr_ch0,
    input  logic [CMD_W-1:0] fifo_din_cmd_ch1,
    input  logic             fifo_wr_en_cmd_ch1,
    output logic             fifo_full_cmd_ch1,
    input  logic [DAT_W-1:0] fifo_din_wr_ch1,
    input  logic             fifo_wr_en_wr_ch1,
    output logic             fifo_full_wr_ch1,
    output logic [CMD_W-1:0] fifo_din_cmd_o,
    output logic             fifo_wr_en_cmd_o,
    input  logic             fifo_full_cmd_i,
    output logic [DAT_W-1:0] fifo_din_wr_o,
    output logic             fifo_wr_en_wr_o,
    input  logic             fifo_full_wr_i,
    output logic [1:0]       grant,
    output logic             err_orphan
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;      // 1: channel 1 was granted last
    logic [19:0]      cnt_q, cnt_d;        // outstanding data beats
    logic             err_q, err_d;
    logic [CMD_W-1:0] cmd_o_q, cmd_o_d;
    logic             cmd_we_q, cmd_we_d;
    logic [DAT_W-1:0] wr_o_q, wr_o_d;
    logic             wr_we_q, wr_we_d;

    logic             own_req;
    logic             own_cmd_we;
    logic             own_wr_we;
    logic [CMD_W-1:0] own_cmd;
    logic [DAT_W-1:0] own_wr;
    logic [23:0]      btt_rnd;
    logic [19:0]      add_beats;
    logic [19:0]      sum;

    // Select the granted channel's inputs; nothing is owned in IDLE.
    always_comb begin
        own_req    = 1'b0;
        own_cmd_we = 1'b0;
        own_wr_we  = 1'b0;
        own_cmd    = fifo_din_cmd_ch0;
        own_wr     = fifo_din_wr_ch0;
        case (state_q)
            GNT0: begin
                own_req    = req_ch0;
                own_cmd_we = fifo_wr_en_cmd_ch0;
                own_wr_we  = fifo_wr_en_wr_ch0;
            end
            GNT1: begin
                own_req    = req_ch1;
                own_cmd_we = fifo_wr_en_cmd_ch1;
                own_wr_we  = fifo_wr_en_wr_ch1;
                own_cmd    = fifo_din_cmd_ch1;
                own_wr     = fifo_din_wr_ch1;
            end
            default: ;
        endcase
    end

    // Next-state, outstanding-beat accounting and output register loads.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        cmd_o_d   = cmd_o_q;
        cmd_we_d  = 1'b0;
        wr_o_d    = wr_o_q;
        wr_we_d   = 1'b0;
        btt_rnd   = {1'b0, own_cmd[22:0]} + 24'd15;
        add_beats = own_cmd_we ? btt_rnd[23:4] : '0;
        sum       = cnt_q + add_beats;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_ch0 && (!req_ch1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req_ch1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0, GNT1: begin
                if (own_cmd_we) begin
                    cmd_o_d  = own_cmd;
                    cmd_we_d = 1'b1;
                end
                // Beat with nothing outstanding (including a same-cycle
                // command) is forwarded, flagged, and the count holds at 0.
                if (own_wr_we) begin
                    wr_o_d  = own_wr;
                    wr_we_d = 1'b1;
                    if (sum == '0) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = sum - 20'd1;
                    end
                end else begin
                    cnt_d = sum;
                end
                if (!own_req && cnt_q == '0 && !own_cmd_we && !own_wr_we) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and one-stage output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            cmd_o_q  <= '0;
            cmd_we_q <= 1'b0;
            wr_o_q   <= '0;
            wr_we_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            cmd_o_q  <= cmd_o_d;
            cmd_we_q <= cmd_we_d;
            wr_o_q   <= wr_o_d;
            wr_we_q  <= wr_we_d;
        end
    end

    // Back-pressure: owner sees the shared FIFO state, everyone else sees full.
    always_comb begin
        fifo_full_cmd_ch0 = 1'b1;
        fifo_full_wr_ch0  = 1'b1;
        fifo_full_cmd_ch1 = 1'b1;
        fifo_full_wr_ch1  = 1'b1;
        grant             = 2'b00;
        case (state_q)
            GNT0: begin
                fifo_full_cmd_ch0 = fifo_full_cmd_i;
                fifo_full_wr_ch0  = fifo_full_wr_i;
                grant             = 2'b01;
            end
            GNT1: begin
                fifo_full_cmd_ch1 = fifo_full_cmd_i;
                fifo_full_wr_ch1  = fifo_full_wr_i;
                grant             = 2'b10;
            end
            default: ;
        endcase
    end

    assign fifo_din_cmd_o   = cmd_o_q;
    assign fifo_wr_en_cmd_o = cmd_we_q;
    assign fifo_din_wr_o    = wr_o_q;
    assign fifo_wr_en_wr_o  = wr_we_q;
    assign err_orphan       = err_q;

endmodule

// File: tb/tb_fifo2axi_arb.sv
// Directed, table-driven bench for fifo2axi_arb: each record is one cycle of
// inputs plus the outputs expected just after the clock edge that samples it.
module tb_fifo2axi_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_ch0 = 0, req_ch1 = 0;
    logic [63:0]  din_cmd0 = '0, din_cmd1 = '0;
    logic         we_cmd0 = 0, we_cmd1 = 0;
    logic [127:0] din_wr0 = '0, din_wr1 = '0;
    logic         we_wr0 = 0, we_wr1 = 0;
    logic         full_cmd0, full_wr0, full_cmd1, full_wr1;
    logic [63:0]  cmd_o;
    logic         cmd_we_o;
    logic         full_cmd_i = 0;
    logic [127:0] wr_o;
    logic         wr_we_o;
    logic         full_wr_i = 0;
    logic [1:0]   grant;
    logic         err_orphan;

    int n_cmp = 0;
    int n_bad = 0;

    fifo2axi_arb #(.CMD_W(64), .DAT_W(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_ch0(req_ch0), .req_ch1(req_ch1),
        .fifo_din_cmd_ch0(din_cmd0), .fifo_wr_en_cmd_ch0(we_cmd0), .fifo_full_cmd_ch0(full_cmd0),
        .fifo_din_wr_ch0(din_wr0), .fifo_wr_en_wr_ch0(we_wr0), .fifo_full_wr_ch0(full_wr0),
        .fifo_din_cmd_ch1(din_cmd1), .fifo_wr_en_cmd_ch1(we_cmd1), .fifo_full_cmd_ch1(full_cmd1),
        .fifo_din_wr_ch1(din_wr1), .fifo_wr_en_wr_ch1(we_wr1), .fifo_full_wr_ch1(full_wr1),
        .fifo_din_cmd_o(cmd_o), .fifo_wr_en_cmd_o(cmd_we_o), .fifo_full_cmd_i(full_cmd_i),
        .fifo_din_wr_o(wr_o), .fifo_wr_en_wr_o(wr_we_o), .fifo_full_wr_i(full_wr_i),
        .grant(grant), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, c0, d0, c1, d1, fc, fw;
        logic [22:0] btt;
        logic [1:0]  g;
        logic        oc, ow, err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic r0, r1, c0, d0, c1, d1, fc, fw,
                               input int btt, input logic [1:0] g,
                               input logic oc, ow, err);
        vec_t x;
        x.r0 = r0; x.r1 = r1; x.c0 = c0; x.d0 = d0; x.c1 = c1; x.d1 = d1;
        x.fc = fc; x.fw = fw; x.btt = 23'(btt); x.g = g;
        x.oc = oc; x.ow = ow; x.err = err;
        return x;
    endfunction

    function automatic logic [63:0] cmd_word(input logic ch, input int idx, input logic [22:0] btt);
        logic [31:0] addr;
        addr = 32'hA000_0000 + (ch ? 32'h0001_0000 : 32'h0) + 32'(idx);
        return {addr, 9'h000, btt};
    endfunction

    function automatic logic [127:0] dat_word(input logic ch, input int idx);
        logic [31:0] w;
        w = (ch ? 32'hD1D1_0000 : 32'hD0D0_0000) + 32'(idx);
        return {4{w}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " grant"}, 128'(grant), 128'(2'b00));
        chk({tag, " fulls"}, 128'({full_cmd0, full_wr0, full_cmd1, full_wr1}), 128'(4'b1111));
        chk({tag, " wr_en_o"}, 128'({cmd_we_o, wr_we_o}), 128'(2'b00));
        chk({tag, " cmd_o"}, 128'(cmd_o), 128'(0));
        chk({tag, " wr_o"}, wr_o, 128'(0));
        chk({tag, " err"}, 128'(err_orphan), 128'(0));
    endtask

    initial begin
        logic [1:0] prev_g;
        logic [3:0] exp_full;
        logic       src;

        //              r0 r1 c0 d0 c1 d1 fc fw btt  g    oc ow err
        // contention from reset, ch0 first, then ch1, then ch0 again
        vt.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0,  2'b01, 0, 0, 0)); // 0
        vt.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0)); // 1 release
        vt.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  2'b10, 0, 0, 0)); // 2
        vt.push_back(v(1, 1, 1, 0, 1, 0, 0, 0, 16, 2'b10, 1, 0, 0)); // 3 ch0 strobe dropped
        vt.push_back(v(1, 1, 0, 1, 0, 1, 0, 0, 0,  2'b10, 0, 1, 0)); // 4
        vt.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0)); // 5
        vt.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0,  2'b01, 0, 0, 0)); // 6 round robin
        // single channel BTT=64 -> 4 beats
        vt.push_back(v(1, 1, 1, 0, 0, 0, 0, 0, 64, 2'b01, 1, 0, 0)); // 7
        vt.push_back(v(1, 1, 0, 1, 0, 0, 0, 0, 0,  2'b01, 0, 1, 0)); // 8
        vt.push_back(v(1, 1, 0, 1, 0, 0, 0, 0, 0,  2'b01, 0, 1, 0)); // 9
        vt.push_back(v(1, 1, 0, 1, 0, 0, 0, 0, 0,  2'b01, 0, 1, 0)); // 10
        vt.push_back(v(0, 1, 0, 1, 0, 0, 0, 0, 0,  2'b01, 0, 1, 0)); // 11 last beat
        vt.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0)); // 12
        vt.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  2'b10, 0, 0, 0)); // 13
        // back-pressure on ch1, BTT=48 -> 3 beats
        vt.push_back(v(0, 1, 0, 0, 1, 0, 0, 0, 48, 2'b10, 1, 0, 0)); // 14
        vt.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0,  2'b10, 0, 1, 0)); // 15
        vt.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0,  2'b10, 0, 0, 0)); // 16
        vt.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0,  2'b10, 0, 0, 0)); // 17
        vt.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0,  2'b10, 0, 1, 0)); // 18
        vt.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0,  2'b10, 0, 1, 0)); // 19
        vt.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0)); // 20
        vt.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  2'b01, 0, 0, 0)); // 21
        // burst lock: BTT=32, req dropped after first beat
        vt.push_back(v(1, 1, 1, 0, 0, 0, 0, 0, 32, 2'b01, 1, 0, 0)); // 22
        vt.push_back(v(0, 1, 0, 1, 0, 0, 0, 0, 0,  2'b01, 0, 1, 0)); // 23
        vt.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  2'b01, 0, 0, 0)); // 24 held
        vt.push_back(v(0, 1, 0, 1, 0, 0, 0, 0, 0,  2'b01, 0, 1, 0)); // 25
        vt.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0)); // 26
        vt.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  2'b10, 0, 0, 0)); // 27
        // odd size BTT=17 -> 2 beats, third beat is orphan
        vt.push_back(v(0, 1, 0, 0, 1, 0, 0, 0, 17, 2'b10, 1, 0, 0)); // 28
        vt.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0,  2'b10, 0, 1, 0)); // 29
        vt.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0,  2'b10, 0, 1, 0)); // 30
        vt.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0,  2'b10, 0, 1, 1)); // 31
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 1)); // 32
        // same-cycle cmd+data, BTT=0 command
        vt.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  2'b01, 0, 0, 1)); // 33
        vt.push_back(v(1, 0, 1, 1, 0, 0, 0, 0, 32, 2'b01, 1, 1, 1)); // 34
        vt.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 0,  2'b01, 1, 0, 1)); // 35
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0,  2'b01, 0, 0, 1)); // 36 one beat left
        vt.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0,  2'b01, 0, 1, 1)); // 37
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 1)); // 38

        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;

        prev_g = 2'b00;
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            req_ch0 = vt[i].r0;  req_ch1 = vt[i].r1;
            we_cmd0 = vt[i].c0;  we_wr0 = vt[i].d0;
            we_cmd1 = vt[i].c1;  we_wr1 = vt[i].d1;
            full_cmd_i = vt[i].fc; full_wr_i = vt[i].fw;
            din_cmd0 = cmd_word(1'b0, i, vt[i].btt);
            din_cmd1 = cmd_word(1'b1, i, vt[i].btt);
            din_wr0  = dat_word(1'b0, i);
            din_wr1  = dat_word(1'b1, i);
            @(posedge clk);
            #1;
            src = (prev_g == 2'b10);
            exp_full = 4'b1111;
            if (vt[i].g == 2'b01) exp_full[3:2] = {vt[i].fc, vt[i].fw};
            if (vt[i].g == 2'b10) exp_full[1:0] = {vt[i].fc, vt[i].fw};
            chk($sformatf("v%0d grant", i), 128'(grant), 128'(vt[i].g));
            chk($sformatf("v%0d fulls", i), 128'({full_cmd0, full_wr0, full_cmd1, full_wr1}), 128'(exp_full));
            chk($sformatf("v%0d cmd_we_o", i), 128'(cmd_we_o), 128'(vt[i].oc));
            chk($sformatf("v%0d wr_we_o", i), 128'(wr_we_o), 128'(vt[i].ow));
            chk($sformatf("v%0d err", i), 128'(err_orphan), 128'(vt[i].err));
            if (vt[i].oc) chk($sformatf("v%0d cmd_o", i), 128'(cmd_o), 128'(cmd_word(src, i, vt[i].btt)));
            if (vt[i].ow) chk($sformatf("v%0d wr_o", i), wr_o, dat_word(src, i));
            prev_g = vt[i].g;
        end

        // Reset mid-burst on ch1, then contention must go to ch0 first.
        @(negedge clk);
        req_ch0 = 0; req_ch1 = 1; we_cmd0 = 0; we_wr0 = 0; we_cmd1 = 0; we_wr1 = 0;
        full_cmd_i = 0; full_wr_i = 0;
        @(posedge clk); #1 chk("mid grant10", 128'(grant), 128'(2'b10));
        @(negedge clk) begin we_cmd1 = 1; din_cmd1 = cmd_word(1'b1, 100, 23'd64); end
        @(posedge clk); #1 chk("mid cmd_we", 128'(cmd_we_o), 128'(1));
        @(negedge clk) begin we_cmd1 = 0; we_wr1 = 1; din_wr1 = dat_word(1'b1, 101); end
        @(posedge clk); #1 chk("mid wr_o", wr_o, dat_word(1'b1, 101));
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1; we_wr1 = 0; req_ch0 = 1; req_ch1 = 1;
        @(posedge clk); #1 chk("post-reset grant01", 128'(grant), 128'(2'b01));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
